// File: rtl/ifu_pkg.sv
// Shared fetch-queue types and default sizing for the instruction fetch unit.
package ifu_pkg;
  localparam int IFU_ADDR_W   = 32;
  localparam int IFU_INST_W   = 32;
  localparam int FQ_DEPTH_DEF = 4;
  localparam int FQ_OUTST_DEF = 2;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_INST_W-1:0] inst;
  } t_fetch_entry;
endpackage

// File: rtl/ifu_fq_fifo.sv
// Sync FIFO with flush: head is readable with zero latency, push visible next cycle.
// Push while full is ignored unless a pop frees the slot in the same cycle; flush wins.
module ifu_fq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/ifu_fetch_queue.sv
// Decoupled fetch front-end: credit-limited sequential requests, in-order entry queue, redirect flush.
// Response reaches deq_* one cycle later; requests stall when queue slots plus in-flight reach DEPTH.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int                ADDR_W    = IFU_ADDR_W,
  parameter int                INST_W    = IFU_INST_W,
  parameter int                DEPTH     = FQ_DEPTH_DEF,
  parameter int                MAX_OUTST = FQ_OUTST_DEF,
  parameter int                PC_STEP   = 4,
  parameter logic [ADDR_W-1:0] RST_PC    = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [ADDR_W-1:0]          req_addr_o,
  input  logic                       rsp_valid_i,
  input  logic [INST_W-1:0]          rsp_inst_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [ADDR_W-1:0]          deq_pc_o,
  output logic [INST_W-1:0]          deq_inst_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [OUT_W-1:0]  discard_q, discard_d;
  logic              credit_ok, req_hs, deq_hs, rsp_keep, tag_pop;
  logic [ADDR_W-1:0] tag_pc;
  logic [OUT_W-1:0]  tag_count;
  logic              tag_empty, tag_full, q_empty, q_full;
  fetch_entry_t      q_push_dat, q_head;

  // Every in-flight request owns a queue slot, so responses can never be refused.
  assign credit_ok   = (32'(occupancy_o) + 32'(outst_q) < 32'(DEPTH)) &&
                       (32'(outst_q) < 32'(MAX_OUTST));
  assign req_valid_o = !rst_i && !redirect_i && credit_ok;
  assign req_addr_o  = fetch_pc_q;
  assign req_hs      = req_valid_o && req_ready_i;

  // Stale tags were flushed at redirect, so stale responses must not pop the tag FIFO.
  assign tag_pop     = rsp_valid_i && (discard_q == '0);
  assign rsp_keep    = tag_pop && !redirect_i;

  assign deq_valid_o = !q_empty && !redirect_i;
  assign deq_hs      = deq_valid_o && deq_ready_i;
  assign deq_pc_o    = q_head.pc;
  assign deq_inst_o  = q_head.inst;
  assign q_push_dat  = '{pc: tag_pc, inst: rsp_inst_i};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + OUT_W'(req_hs) - OUT_W'(rsp_valid_i);
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      discard_d  = outst_q - OUT_W'(rsp_valid_i);
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp_valid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RST_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  ifu_fq_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .push_i     (req_hs),
    .push_dat_i (fetch_pc_q),
    .pop_i      (tag_pop),
    .head_dat_o (tag_pc),
    .count_o    (tag_count),
    .empty_o    (tag_empty),
    .full_o     (tag_full)
  );

  ifu_fq_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .push_i     (rsp_keep),
    .push_dat_i (q_push_dat),
    .pop_i      (deq_hs),
    .head_dat_o (q_head),
    .count_o    (occupancy_o),
    .empty_o    (q_empty),
    .full_o     (q_full)
  );

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i |-> (outst_q != '0));
  a_tag_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    req_hs |-> !tag_full);
  a_tag_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_keep |-> !tag_empty);
  a_tag_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    tag_count <= outst_q);
  a_queue_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_keep |-> (!q_full || deq_hs));
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench: stimulus pushes expected requests/dequeues, a monitor pops and compares.
module tb_ifu_fetch_queue;
  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  logic        clk_i, rst_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_inst_i;
  logic        deq_valid_o, deq_ready_i;
  logic [31:0] deq_pc_o, deq_inst_o;
  logic [2:0]  occupancy_o;

  ifu_fetch_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid_i), .rsp_inst_i(rsp_inst_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_pc_o(deq_pc_o),
    .deq_inst_o(deq_inst_o), .occupancy_o(occupancy_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          req_cnt  = 0;
  int          inflight = 0;
  int          release_tgt = 0;
  int          released = 0;
  bit          auto_rsp = 0;
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_deq_q[$];
  logic [31:0] pending[$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_pc(input logic [31:0] pc, input bit deq);
    exp_req_q.push_back(pc);
    if (deq) exp_deq_q.push_back(pc);
  endtask

  task automatic issue_n(input int n);
    int target;
    target = req_cnt + n;
    req_ready_i = 1'b1;
    for (int i = 0; i < 200 && req_cnt < target; i++) @(negedge clk_i);
    req_ready_i = 1'b0;
    if (req_cnt < target) fail_now("issue_timeout");
  endtask

  task automatic drain();
    deq_ready_i = 1'b1;
    for (int i = 0; i < 200 && exp_deq_q.size() != 0; i++) @(negedge clk_i);
    check("drain_done", 64'(exp_deq_q.size()), 64'd0);
    repeat (3) @(negedge clk_i);
  endtask

  // Cache model: in-order, replies one cycle after acceptance (auto) or on release credit.
  initial begin
    rsp_valid_i = 1'b0;
    rsp_inst_i  = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        pending.delete();
        rsp_valid_i = 1'b0;
      end else if (pending.size() != 0 && (auto_rsp || released < release_tgt)) begin
        rsp_valid_i = 1'b1;
        rsp_inst_i  = pending.pop_front() ^ KEY;
        if (!auto_rsp) released++;
      end else begin
        rsp_valid_i = 1'b0;
      end
      #3;
      if (!rst_i && req_valid_o && req_ready_i) pending.push_back(req_addr_o);
    end
  end

  // Monitor: compares every request and dequeue handshake against the scoreboards.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_i) begin
        inflight = 0;
      end else begin
        if (req_valid_o && req_ready_i) begin
          check("outst_le_max", 64'((inflight + 1 - int'(rsp_valid_i)) <= 2), 64'd1);
          if (exp_req_q.size() == 0) fail_now("unexpected_req");
          else begin
            e = exp_req_q.pop_front();
            check("req_addr", 64'(req_addr_o), 64'(e));
          end
          req_cnt++;
        end
        if (deq_valid_o && deq_ready_i) begin
          if (exp_deq_q.size() == 0) fail_now("unexpected_deq");
          else begin
            e = exp_deq_q.pop_front();
            check("deq_pc", 64'(deq_pc_o), 64'(e));
            check("deq_inst", 64'(deq_inst_o), 64'(e ^ KEY));
          end
        end
        inflight = inflight + int'(req_valid_o && req_ready_i) - int'(rsp_valid_i);
      end
    end
  end

  initial begin
    int c0;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    req_ready_i = 1'b0; deq_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #3;
    check("rst_req_valid", 64'(req_valid_o), 64'd0);
    check("rst_req_addr", 64'(req_addr_o), 64'd0);
    check("rst_deq_valid", 64'(deq_valid_o), 64'd0);
    check("rst_occupancy", 64'(occupancy_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // 1: streaming from reset
    expect_pc(32'h0, 1); expect_pc(32'h4, 1); expect_pc(32'h8, 1); expect_pc(32'hC, 1);
    auto_rsp = 1; deq_ready_i = 1'b1;
    issue_n(4);
    drain();

    // 2: core stalled, queue fills, one pop frees exactly one credit
    expect_pc(32'h10, 1); expect_pc(32'h14, 1); expect_pc(32'h18, 1);
    expect_pc(32'h1C, 1); expect_pc(32'h20, 1);
    deq_ready_i = 1'b0; c0 = req_cnt; req_ready_i = 1'b1;
    repeat (12) @(negedge clk_i);
    #3;
    check("t2_four_reqs", 64'(req_cnt - c0), 64'd4);
    check("t2_occ_full", 64'(occupancy_o), 64'd4);
    check("t2_req_blocked", 64'(req_valid_o), 64'd0);
    @(negedge clk_i); deq_ready_i = 1'b1;
    @(negedge clk_i); deq_ready_i = 1'b0;
    repeat (6) @(negedge clk_i);
    #3;
    check("t2_one_more_req", 64'(req_cnt - c0), 64'd5);
    check("t2_occ_refull", 64'(occupancy_o), 64'd4);
    @(negedge clk_i); req_ready_i = 1'b0;
    drain();

    // 3: redirect with two stale requests in flight
    expect_pc(32'h24, 0); expect_pc(32'h28, 0);
    expect_pc(32'h100, 1); expect_pc(32'h104, 1);
    auto_rsp = 0;
    issue_n(2);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(negedge clk_i); redirect_i = 1'b0; auto_rsp = 1;
    #3;
    check("t3_discard_2", 64'(dut.discard_q), 64'd2);
    issue_n(2);
    drain();
    check("t3_discard_0", 64'(dut.discard_q), 64'd0);

    // 4: response lands in the redirect cycle, one more stale in flight
    expect_pc(32'h108, 0); expect_pc(32'h10C, 0); expect_pc(32'h200, 1);
    auto_rsp = 0;
    issue_n(2);
    redirect_i = 1'b1; redirect_pc_i = 32'h200; release_tgt = release_tgt + 1;
    @(negedge clk_i); redirect_i = 1'b0; auto_rsp = 1;
    #3;
    check("t4_discard_1", 64'(dut.discard_q), 64'd1);
    issue_n(1);
    drain();

    // 5: address wrap
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    #3;
    check("t5_redirect_blocks_req", 64'(req_valid_o), 64'd0);
    @(negedge clk_i); redirect_i = 1'b0;
    expect_pc(32'hFFFF_FFF8, 1); expect_pc(32'hFFFF_FFFC, 1); expect_pc(32'h0, 1);
    issue_n(3);
    drain();

    // 6: reset mid-stream with two outstanding and one queued entry
    expect_pc(32'h4, 0); expect_pc(32'h8, 0); expect_pc(32'hC, 0);
    auto_rsp = 0; deq_ready_i = 1'b0;
    issue_n(2);
    release_tgt = release_tgt + 1;
    repeat (3) @(negedge clk_i);
    #3;
    check("t6_occ_1", 64'(occupancy_o), 64'd1);
    @(negedge clk_i);
    issue_n(1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_req_valid", 64'(req_valid_o), 64'd0);
    check("t6_rst_req_addr", 64'(req_addr_o), 64'd0);
    check("t6_rst_deq_valid", 64'(deq_valid_o), 64'd0);
    check("t6_rst_occupancy", 64'(occupancy_o), 64'd0);
    check("t6_rst_outst", 64'(dut.outst_q), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    expect_pc(32'h0, 1);
    auto_rsp = 1; deq_ready_i = 1'b1;
    issue_n(1);
    drain();

    check("req_scoreboard_empty", 64'(exp_req_q.size()), 64'd0);
    check("deq_scoreboard_empty", 64'(exp_deq_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
